// File: rtl/vp_pkg.sv
// Shared types and helpers for the stride value predictor.
//   entry_t  : unpacked view of one table entry; stride is held sign-extended
//              to 32 bits and conf zero-extended, so arithmetic is width-agnostic.
//   state_e  : table controller states (INIT sweep, RUN).
//   conf_max / sext_stride / stride_fits : saturation and stride range helpers.
package vp_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int STRIDE_WIDTH_MIN  = 2;
    localparam int STRIDE_WIDTH_MAX  = 32;
    localparam int NUM_PRED_MAX      = 4;

    typedef struct packed {
        logic [31:0] last;
        logic [31:0] stride;
        logic [31:0] conf;
    } entry_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // All-ones value of a (conf_width+1)-bit confidence counter.
    function automatic logic [31:0] conf_max(input int conf_width);
        return (32'd1 << (conf_width + 1)) - 32'd1;
    endfunction

    // Keep the low stride_width bits of value and sign-extend them to 32 bits.
    function automatic logic [31:0] sext_stride(input logic [31:0] value, input int stride_width);
        logic signed [31:0] tmp;
        tmp = $signed(value << (32 - stride_width));
        return 32'(tmp >>> (32 - stride_width));
    endfunction

    // True when delta survives a round trip through a stride_width signed field.
    function automatic logic stride_fits(input logic [31:0] delta, input int stride_width);
        return (sext_stride(delta, stride_width) == delta);
    endfunction

endpackage

// File: rtl/stride_pred_if.sv
// Bundle of lookup, prediction and feedback signals of the stride predictor.
//   fw_*   : lookup request (PC, qualifier) per channel
//   pred_* : registered prediction per channel (PC, value, confidence, qualifier)
//   fb_*   : executed-result feedback per channel (PC, value, qualifier)
//   ready_o: table has finished its clearing sweep
// master = requester/testbench side, slave = predictor side.
interface stride_pred_if #(
    parameter int P_NUM_PRED = 2
);
    logic [P_NUM_PRED-1:0][31:1] fw_pc_i;
    logic [P_NUM_PRED-1:0]       fw_valid_i;
    logic [P_NUM_PRED-1:0][31:1] pred_pc_o;
    logic [P_NUM_PRED-1:0][31:0] pred_result_o;
    logic [P_NUM_PRED-1:0]       pred_conf_o;
    logic [P_NUM_PRED-1:0]       pred_valid_o;
    logic [P_NUM_PRED-1:0][31:1] fb_pc_i;
    logic [P_NUM_PRED-1:0][31:0] fb_actual_i;
    logic [P_NUM_PRED-1:0]       fb_valid_i;
    logic                        ready_o;

    modport master (
        output fw_pc_i, fw_valid_i, fb_pc_i, fb_actual_i, fb_valid_i,
        input  pred_pc_o, pred_result_o, pred_conf_o, pred_valid_o, ready_o
    );

    modport slave (
        input  fw_pc_i, fw_valid_i, fb_pc_i, fb_actual_i, fb_valid_i,
        output pred_pc_o, pred_result_o, pred_conf_o, pred_valid_o, ready_o
    );
endinterface

// File: rtl/stride_pred_update.sv
// Next-state arithmetic for one table entry given one executed result.
//   entry_i  : current entry (stride sign-extended, conf zero-extended)
//   actual_i : executed result
//   entry_o  : updated entry
// A matching delta bumps confidence (saturating); a mismatch clears it and
// adopts the new delta as stride when it fits the stored width, else zero.
module stride_pred_update
    import vp_pkg::*;
#(
    parameter int P_STRIDE_WIDTH = 8,
    parameter int P_CONF_WIDTH   = 8
) (
    input  entry_t      entry_i,
    input  logic [31:0] actual_i,
    output entry_t      entry_o
);

    localparam logic [31:0] LP_CONF_MAX = conf_max(P_CONF_WIDTH);

    logic [31:0] delta_s;
    logic        hit_s;

    // Compare the observed delta with the stored stride and build the new entry.
    always_comb begin
        delta_s      = actual_i - entry_i.last;
        hit_s        = (delta_s == entry_i.stride);
        entry_o      = entry_i;
        entry_o.last = actual_i;
        if (hit_s) begin
            if (entry_i.conf >= LP_CONF_MAX) begin
                entry_o.conf = LP_CONF_MAX;
            end else begin
                entry_o.conf = entry_i.conf + 32'd1;
            end
        end else begin
            entry_o.conf = 32'd0;
            if (stride_fits(delta_s, P_STRIDE_WIDTH)) begin
                entry_o.stride = delta_s;
            end else begin
                entry_o.stride = 32'd0;
            end
        end
    end

endmodule

// File: rtl/stride_pred_top.sv
// Stride value predictor: a PC-indexed table of {last, stride, conf}.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus (slave)  : lookup, prediction, feedback and ready signals
// After reset the table is cleared one entry per cycle (INIT), then the block
// serves lookups with one cycle of latency and applies feedback (RUN).
// Feedback channels hitting the same index in one cycle are chained in channel
// order; only the last channel of such a group writes the table.
module stride_pred_top
    import vp_pkg::*;
#(
    parameter int P_STORAGE_SIZE = 2048,
    parameter int P_CONF_WIDTH   = 8,
    parameter int P_NUM_PRED     = 2,
    parameter int P_STRIDE_WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    stride_pred_if.slave   bus
);

    localparam int P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE);
    localparam int LP_EW         = 32 + P_STRIDE_WIDTH + P_CONF_WIDTH + 1;
    localparam logic [P_INDEX_WIDTH-1:0] LP_LAST_IDX = P_INDEX_WIDTH'(P_STORAGE_SIZE - 1);

    typedef logic [LP_EW-1:0] raw_t;

    raw_t                            mem_q [P_STORAGE_SIZE];
    state_e                          state_q;
    logic [P_INDEX_WIDTH-1:0]        sweep_q;
    logic                            ready_q;
    logic [P_NUM_PRED-1:0][31:1]     pred_pc_q;
    logic [P_NUM_PRED-1:0][31:0]     pred_result_q;
    logic [P_NUM_PRED-1:0][31:0]     pred_result_d;
    logic [P_NUM_PRED-1:0]           pred_conf_q;
    logic [P_NUM_PRED-1:0]           pred_conf_d;
    logic [P_NUM_PRED-1:0]           pred_valid_q;
    logic [P_NUM_PRED-1:0]           pred_valid_d;

    logic [P_INDEX_WIDTH-1:0]        fw_idx_s [P_NUM_PRED];
    logic [P_INDEX_WIDTH-1:0]        fb_idx_s [P_NUM_PRED];
    entry_t                          fw_rd_s  [P_NUM_PRED];
    entry_t                          fb_rd_s  [P_NUM_PRED];
    logic [P_NUM_PRED-1:0]           wr_en_s;
    logic [P_NUM_PRED-1:0][LP_EW-1:0] wr_data_s;
    logic                            unused_fw_s;
    logic                            unused_fb_pc_s;

    // Stored layout {last, stride, conf} widened to the arithmetic view.
    function automatic entry_t unpack_entry(input raw_t raw);
        entry_t e;
        e.last   = raw[LP_EW-1 -: 32];
        e.stride = sext_stride(32'(raw[P_CONF_WIDTH+1 +: P_STRIDE_WIDTH]), P_STRIDE_WIDTH);
        e.conf   = 32'(raw[P_CONF_WIDTH:0]);
        return e;
    endfunction

    // Table indices and asynchronous reads for lookup and feedback channels.
    always_comb begin
        unused_fw_s = 1'b0;
        for (int c = 0; c < P_NUM_PRED; c++) begin
            fw_idx_s[c] = bus.fw_pc_i[c][P_INDEX_WIDTH:1];
            fb_idx_s[c] = bus.fb_pc_i[c][P_INDEX_WIDTH:1];
            fw_rd_s[c]  = unpack_entry(mem_q[fw_idx_s[c]]);
            fb_rd_s[c]  = unpack_entry(mem_q[fb_idx_s[c]]);
            unused_fw_s = unused_fw_s ^ (^fw_rd_s[c].conf);
        end
    end

    assign unused_fb_pc_s = ^bus.fb_pc_i;

    // Prediction values; the table read reflects writes up to the previous edge.
    always_comb begin
        for (int c = 0; c < P_NUM_PRED; c++) begin
            if (state_q == ST_RUN) begin
                pred_result_d[c] = fw_rd_s[c].last + fw_rd_s[c].stride;
                pred_conf_d[c]   = fw_rd_s[c].conf[P_CONF_WIDTH];
                pred_valid_d[c]  = bus.fw_valid_i[c];
            end else begin
                pred_result_d[c] = 32'd0;
                pred_conf_d[c]   = 1'b0;
                pred_valid_d[c]  = 1'b0;
            end
        end
    end

    // Update chain: each channel starts from the most recent earlier same-index result.
    for (genvar c = 0; c < P_NUM_PRED; c++) begin : g_ch
        entry_t in_s;
        entry_t out_s;
        logic   unused_hi_s;

        if (c == 0) begin : g_first
            assign in_s = fb_rd_s[0];
        end else begin : g_fwd
            for (genvar k = 0; k < c; k++) begin : g_k
                entry_t cand_s;
                if (k == 0) begin : g_base
                    assign cand_s = (bus.fb_valid_i[0] && (fb_idx_s[0] == fb_idx_s[c]))
                                  ? g_ch[0].out_s : fb_rd_s[c];
                end else begin : g_step
                    assign cand_s = (bus.fb_valid_i[k] && (fb_idx_s[k] == fb_idx_s[c]))
                                  ? g_ch[k].out_s : g_k[k-1].cand_s;
                end
            end
            assign in_s = g_k[c-1].cand_s;
        end

        stride_pred_update #(
            .P_STRIDE_WIDTH (P_STRIDE_WIDTH),
            .P_CONF_WIDTH   (P_CONF_WIDTH)
        ) u_update (
            .entry_i  (in_s),
            .actual_i (bus.fb_actual_i[c]),
            .entry_o  (out_s)
        );

        assign wr_data_s[c] = {out_s.last, out_s.stride[P_STRIDE_WIDTH-1:0], out_s.conf[P_CONF_WIDTH:0]};
        assign unused_hi_s  = ^{out_s.stride, out_s.conf};
    end

    // A channel writes only if no later valid channel targets the same index.
    always_comb begin
        for (int c = 0; c < P_NUM_PRED; c++) begin
            wr_en_s[c] = (state_q == ST_RUN) && bus.fb_valid_i[c];
            for (int j = c + 1; j < P_NUM_PRED; j++) begin
                if (bus.fb_valid_i[j] && (fb_idx_s[j] == fb_idx_s[c])) begin
                    wr_en_s[c] = 1'b0;
                end else begin
                    wr_en_s[c] = wr_en_s[c];
                end
            end
        end
    end

    // Table storage: no reset, cleared by the INIT sweep.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_INIT) begin
            mem_q[sweep_q] <= {LP_EW{1'b0}};
        end else begin
            for (int c = 0; c < P_NUM_PRED; c++) begin
                if (wr_en_s[c]) begin
                    mem_q[fb_idx_s[c]] <= wr_data_s[c];
                end
            end
        end
    end

    // Controller FSM and registered prediction outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_INIT;
            sweep_q       <= {P_INDEX_WIDTH{1'b0}};
            ready_q       <= 1'b0;
            pred_pc_q     <= '0;
            pred_result_q <= '0;
            pred_conf_q   <= {P_NUM_PRED{1'b0}};
            pred_valid_q  <= {P_NUM_PRED{1'b0}};
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + P_INDEX_WIDTH'(1);
                    if (sweep_q == LP_LAST_IDX) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_INIT;
                    sweep_q <= {P_INDEX_WIDTH{1'b0}};
                    ready_q <= 1'b0;
                end
            endcase
            pred_pc_q     <= bus.fw_pc_i;
            pred_result_q <= pred_result_d;
            pred_conf_q   <= pred_conf_d;
            pred_valid_q  <= pred_valid_d;
        end
    end

    assign bus.pred_pc_o     = pred_pc_q;
    assign bus.pred_result_o = pred_result_q;
    assign bus.pred_conf_o   = pred_conf_q;
    assign bus.pred_valid_o  = pred_valid_q;
    assign bus.ready_o       = ready_q;

endmodule

// File: tb/tb_stride_pred_top.sv
// Self-checking bench for stride_pred_top with a small behavioural table model.
module tb_stride_pred_top;

    localparam int NP    = 2;
    localparam int STORE = 64;
    localparam int CW    = 2;
    localparam int SW    = 8;
    localparam int CMAX  = (1 << (CW + 1)) - 1;
    localparam int CTHR  = 1 << CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stride_pred_if #(.P_NUM_PRED(NP)) bus ();

    stride_pred_top #(
        .P_STORAGE_SIZE (STORE),
        .P_CONF_WIDTH   (CW),
        .P_NUM_PRED     (NP),
        .P_STRIDE_WIDTH (SW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: plain arrays indexed by table slot
    logic [31:0] m_last   [STORE];
    int          m_stride [STORE];
    int          m_conf   [STORE];
    int          m_cycles;
    bit          m_ready;

    logic [31:0] exp_result [NP];
    bit          exp_conf   [NP];
    bit          exp_valid  [NP];
    logic [31:1] exp_pc     [NP];

    function automatic int idx_of(input logic [31:1] pc);
        return int'(pc) % STORE;
    endfunction

    function automatic logic [31:1] pc_of(input logic [31:0] byte_addr);
        return byte_addr[31:1];
    endfunction

    task automatic clear_inputs();
        for (int c = 0; c < NP; c++) begin
            bus.fw_pc_i[c]     = 31'd0;
            bus.fw_valid_i[c]  = 1'b0;
            bus.fb_pc_i[c]     = 31'd0;
            bus.fb_actual_i[c] = 32'd0;
            bus.fb_valid_i[c]  = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < STORE; i++) begin
            m_last[i]   = 32'd0;
            m_stride[i] = 0;
            m_conf[i]   = 0;
        end
        m_cycles = 0;
        m_ready  = 1'b0;
    endtask

    task automatic model_apply(input int i, input logic [31:0] a);
        int sd;
        sd = int'($signed(a - m_last[i]));
        if (sd == m_stride[i]) begin
            m_conf[i] = (m_conf[i] + 1 > CMAX) ? CMAX : m_conf[i] + 1;
        end else begin
            m_conf[i]   = 0;
            m_stride[i] = (sd >= -(1 << (SW - 1)) && sd < (1 << (SW - 1))) ? sd : 0;
        end
        m_last[i] = a;
    endtask

    // one clock: expected outputs from pre-edge state, then apply feedback in channel order
    task automatic advance();
        for (int c = 0; c < NP; c++) begin
            int i;
            i = idx_of(bus.fw_pc_i[c]);
            exp_pc[c]    = bus.fw_pc_i[c];
            exp_valid[c] = bus.fw_valid_i[c] && m_ready;
            exp_result[c] = m_ready ? m_last[i] + 32'(m_stride[i]) : 32'd0;
            exp_conf[c]   = m_ready ? (m_conf[i] >= CTHR) : 1'b0;
        end
        if (m_ready) begin
            for (int c = 0; c < NP; c++) begin
                if (bus.fb_valid_i[c]) model_apply(idx_of(bus.fb_pc_i[c]), bus.fb_actual_i[c]);
            end
        end
        @(posedge clk);
        if (!m_ready) begin
            m_cycles++;
            if (m_cycles >= STORE) m_ready = 1'b1;
        end
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 4 * STORE) begin
            advance();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b expected 0", bus.ready_o); end
        checks++; if (bus.pred_valid_o !== NP'(0)) begin errors++; $display("FAIL rst_valid: got %0h expected 0", bus.pred_valid_o); end
        checks++; if (bus.pred_result_o !== '0) begin errors++; $display("FAIL rst_result: got %0h expected 0", bus.pred_result_o); end
        checks++; if (bus.pred_conf_o !== NP'(0)) begin errors++; $display("FAIL rst_conf: got %0h expected 0", bus.pred_conf_o); end
        rst = 1'b0;
        model_reset();
        n = 0;
        seen = 1'b0;
        while (!seen && n < 4 * STORE) begin
            for (int c = 0; c < NP; c++) begin
                bus.fw_valid_i[c]  = 1'b1;
                bus.fw_pc_i[c]     = pc_of(32'h100);
                bus.fb_valid_i[c]  = 1'b1;
                bus.fb_pc_i[c]     = pc_of(32'h100 + 32'(c * 4));
                bus.fb_actual_i[c] = $urandom;
            end
            advance();
            n++;
            checks++; if (bus.pred_valid_o !== NP'(0)) begin errors++; $display("FAIL init_valid cycle %0d: got %0h expected 0", n, bus.pred_valid_o); end
            checks++; if (bus.ready_o !== m_ready) begin errors++; $display("FAIL init_ready cycle %0d: got %0b expected %0b", n, bus.ready_o, m_ready); end
            seen = (bus.ready_o === 1'b1);
        end
        clear_inputs();
        checks++; if (n !== STORE) begin errors++; $display("FAIL init_len: got %0d expected %0d", n, STORE); end
    endtask

    task automatic test_stride_train();
        clear_inputs();
        for (int j = 0; j < 5; j++) begin
            bus.fb_valid_i[0]  = 1'b1;
            bus.fb_pc_i[0]     = pc_of(32'h100);
            bus.fb_actual_i[0] = 32'(10 * (j + 1));
            bus.fw_valid_i[0]  = 1'b1;
            bus.fw_pc_i[0]     = pc_of(32'h100);
            advance();
            checks++; if (bus.pred_result_o[0] !== exp_result[0] || bus.pred_conf_o[0] !== exp_conf[0])
                begin errors++; $display("FAIL train_step%0d: got %0d/%0b expected %0d/%0b", j, bus.pred_result_o[0], bus.pred_conf_o[0], exp_result[0], exp_conf[0]); end
        end
        clear_inputs();
        bus.fw_valid_i[0] = 1'b1;
        bus.fw_pc_i[0]    = pc_of(32'h100);
        bus.fw_valid_i[1] = 1'b1;
        bus.fw_pc_i[1]    = pc_of(32'h104);
        advance();
        checks++; if (bus.pred_result_o[0] !== 32'd60) begin errors++; $display("FAIL train_result: got %0d expected 60", bus.pred_result_o[0]); end
        checks++; if (bus.pred_conf_o[0] !== 1'b1) begin errors++; $display("FAIL train_conf: got %0b expected 1", bus.pred_conf_o[0]); end
        checks++; if (bus.pred_valid_o !== 2'b11) begin errors++; $display("FAIL train_valid: got %0b expected 11", bus.pred_valid_o); end
        checks++; if (bus.pred_pc_o[0] !== pc_of(32'h100)) begin errors++; $display("FAIL train_pc: got %0h expected %0h", bus.pred_pc_o[0], pc_of(32'h100)); end
        checks++; if (bus.pred_result_o[1] !== 32'd0) begin errors++; $display("FAIL train_other: got %0d expected 0", bus.pred_result_o[1]); end
    endtask

    task automatic test_same_cycle();
        clear_inputs();
        for (int c = 0; c < NP; c++) begin
            bus.fb_valid_i[c]  = 1'b1;
            bus.fb_pc_i[c]     = pc_of(32'h100);
            bus.fb_actual_i[c] = 32'(60 + 10 * c);
        end
        advance();
        clear_inputs();
        bus.fw_valid_i[1] = 1'b1;
        bus.fw_pc_i[1]    = pc_of(32'h100);
        advance();
        checks++; if (bus.pred_result_o[1] !== 32'd80) begin errors++; $display("FAIL same_result: got %0d expected 80", bus.pred_result_o[1]); end
        checks++; if (bus.pred_conf_o[1] !== 1'b1) begin errors++; $display("FAIL same_conf: got %0b expected 1", bus.pred_conf_o[1]); end
        checks++; if (bus.pred_valid_o !== 2'b10) begin errors++; $display("FAIL same_valid: got %0b expected 10", bus.pred_valid_o); end
    endtask

    task automatic test_stride_break();
        clear_inputs();
        bus.fb_valid_i[0]  = 1'b1;
        bus.fb_pc_i[0]     = pc_of(32'h100);
        bus.fb_actual_i[0] = 32'd1070;
        advance();
        bus.fb_actual_i[0] = 32'd1080;
        bus.fw_valid_i[0]  = 1'b1;
        bus.fw_pc_i[0]     = pc_of(32'h100);
        advance();
        checks++; if (bus.pred_result_o[0] !== 32'd1070) begin errors++; $display("FAIL break_result: got %0d expected 1070", bus.pred_result_o[0]); end
        checks++; if (bus.pred_conf_o[0] !== 1'b0) begin errors++; $display("FAIL break_conf: got %0b expected 0", bus.pred_conf_o[0]); end
        clear_inputs();
        bus.fw_valid_i[0] = 1'b1;
        bus.fw_pc_i[0]    = pc_of(32'h100);
        advance();
        checks++; if (bus.pred_result_o[0] !== 32'd1090) begin errors++; $display("FAIL restride_result: got %0d expected 1090", bus.pred_result_o[0]); end
        checks++; if (bus.pred_conf_o[0] !== 1'b0) begin errors++; $display("FAIL restride_conf: got %0b expected 0", bus.pred_conf_o[0]); end
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200;
        pool[3] = 32'h17c; pool[4] = 32'h1000; pool[5] = 32'h2046;
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < NP; c++) begin
                int i;
                bus.fw_valid_i[c] = 1'($urandom_range(0, 1));
                bus.fw_pc_i[c]    = pc_of(pool[$urandom_range(0, 5)]);
                bus.fb_valid_i[c] = 1'($urandom_range(0, 1));
                bus.fb_pc_i[c]    = pc_of(pool[$urandom_range(0, 5)]);
                i = idx_of(bus.fb_pc_i[c]);
                case ($urandom_range(0, 3))
                    0, 1:    bus.fb_actual_i[c] = m_last[i] + 32'(m_stride[i]);
                    2:       bus.fb_actual_i[c] = m_last[i] + 32'($urandom_range(0, 400)) - 32'd200;
                    default: bus.fb_actual_i[c] = $urandom;
                endcase
            end
            advance();
            for (int c = 0; c < NP; c++) begin
                checks++; if (bus.pred_valid_o[c] !== exp_valid[c]) begin errors++; $display("FAIL rand_valid t%0d ch%0d: got %0b expected %0b", t, c, bus.pred_valid_o[c], exp_valid[c]); end
                checks++; if (bus.pred_pc_o[c] !== exp_pc[c]) begin errors++; $display("FAIL rand_pc t%0d ch%0d: got %0h expected %0h", t, c, bus.pred_pc_o[c], exp_pc[c]); end
                if (exp_valid[c]) begin
                    checks++; if (bus.pred_result_o[c] !== exp_result[c]) begin errors++; $display("FAIL rand_result t%0d ch%0d: got %0h expected %0h", t, c, bus.pred_result_o[c], exp_result[c]); end
                    checks++; if (bus.pred_conf_o[c] !== exp_conf[c]) begin errors++; $display("FAIL rand_conf t%0d ch%0d: got %0b expected %0b", t, c, bus.pred_conf_o[c], exp_conf[c]); end
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_midrun();
        int n;
        clear_inputs();
        bus.fw_valid_i[0] = 1'b1;
        bus.fw_pc_i[0]    = pc_of(32'h104);
        advance();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL arst_ready: got %0b expected 0", bus.ready_o); end
        checks++; if (bus.pred_valid_o !== NP'(0)) begin errors++; $display("FAIL arst_valid: got %0h expected 0", bus.pred_valid_o); end
        checks++; if (bus.pred_pc_o !== '0) begin errors++; $display("FAIL arst_pc: got %0h expected 0", bus.pred_pc_o); end
        checks++; if (bus.pred_result_o !== '0) begin errors++; $display("FAIL arst_result: got %0h expected 0", bus.pred_result_o); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (20) advance();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wait_ready(n);
        checks++; if (n !== STORE) begin errors++; $display("FAIL reinit_len: got %0d expected %0d", n, STORE); end
        bus.fw_pc_i[0] = pc_of(32'h100);
        advance();
        checks++; if (bus.pred_result_o[0] !== 32'd0) begin errors++; $display("FAIL reinit_result: got %0d expected 0", bus.pred_result_o[0]); end
        checks++; if (bus.pred_conf_o[0] !== 1'b0) begin errors++; $display("FAIL reinit_conf: got %0b expected 0", bus.pred_conf_o[0]); end
        checks++; if (bus.pred_valid_o[0] !== 1'b1) begin errors++; $display("FAIL reinit_valid: got %0b expected 1", bus.pred_valid_o[0]); end
        clear_inputs();
    endtask

    task automatic test_saturate();
        clear_inputs();
        bus.fb_valid_i[0]  = 1'b1;
        bus.fb_pc_i[0]     = pc_of(32'h100);
        bus.fb_actual_i[0] = 32'd10;
        advance();
        bus.fw_valid_i[0] = 1'b1;
        bus.fw_pc_i[0]    = pc_of(32'h100);
        for (int j = 1; j <= 10; j++) begin
            bus.fb_actual_i[0] = 32'(10 + 10 * j);
            advance();
            checks++; if (bus.pred_result_o[0] !== exp_result[0] || bus.pred_conf_o[0] !== exp_conf[0])
                begin errors++; $display("FAIL sat_step%0d: got %0d/%0b expected %0d/%0b", j, bus.pred_result_o[0], bus.pred_conf_o[0], exp_result[0], exp_conf[0]); end
        end
        bus.fb_valid_i[0] = 1'b0;
        advance();
        checks++; if (bus.pred_result_o[0] !== 32'd120) begin errors++; $display("FAIL sat_result: got %0d expected 120", bus.pred_result_o[0]); end
        checks++; if (bus.pred_conf_o[0] !== 1'b1) begin errors++; $display("FAIL sat_conf: got %0b expected 1", bus.pred_conf_o[0]); end
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_stride_train();
        test_same_cycle();
        test_stride_break();
        test_random();
        test_reset_midrun();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
